mac_job_arbiter: RTL and testbench

- Shares one signed 4x4 multiply-accumulate datapath between two requesters.
- Each requester submits a dot-product job: a length, then a stream of operand pairs.
- The block grants requesters round-robin, sequences the accumulation, and returns an 11-bit signed result tagged with the requester id.
- It sits between the operand producers and the downstream result consumer, and has its own internal accumulator.

---
 rtl/mac_job_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mac_job_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_job_arbiter.sv
// Two-requester round-robin arbiter sharing one signed DW x DW multiply-accumulate datapath.
// Optional watchdog abort of stalled jobs is enabled by defining MAC_JOB_ARBITER_TIMEOUT_EN.
module mac_job_arbiter #(
   parameter int DW      = 4,
   parameter int AW      = 11,
   parameter int MAX_LEN = 8,
   parameter int LW      = 4
`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic [LW-1:0] len0,
   input  logic [LW-1:0] len1,
   input  logic [DW-1:0] a0,
   input  logic [DW-1:0] b0,
   input  logic [DW-1:0] a1,
   input  logic [DW-1:0] b1,
   input  logic          valid0,
   input  logic          valid1,
   output logic          ready0,
   output logic          ready1,
   output logic [1:0]    gnt,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [AW-1:0] res_data,
   output logic          res_id,
   output logic          res_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          ptr_q, ptr_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d;

   logic                   win;
   logic [LW-1:0]          len_sel;
   logic [LW-1:0]          len_clamped;
   logic                   beat;
   logic [DW-1:0]          op_a, op_b;
   logic signed [2*DW-1:0] ext_a, ext_b, prod;
   logic [AW-1:0]          prod_ext;

   // With both requesting, the pointer side wins; otherwise whoever is asking.
   assign win         = (req0 && req1) ? ptr_q : req1;
   assign len_sel     = win ? len1 : len0;
   assign len_clamped = (len_sel > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_sel;

   assign op_a     = owner_q ? a1 : a0;
   assign op_b     = owner_q ? b1 : b0;
   assign ext_a    = {{DW{op_a[DW-1]}}, op_a};
   assign ext_b    = {{DW{op_b[DW-1]}}, op_b};
   assign prod     = ext_a * ext_b;
   assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
   assign beat     = (state_q == S_ACCUM) && (owner_q ? valid1 : valid0);

   assign gnt       = (state_q == S_ACCUM) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign ready0    = gnt[0];
   assign ready1    = gnt[1];
   assign res_valid = (state_q == S_DONE);
   assign res_data  = acc_q;
   assign res_id    = owner_q;

`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic           err_q, err_d;
   logic [WDW-1:0] wd_q, wd_d;
   assign res_err = err_q;
`else
   assign res_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
      err_d   = err_q;
      wd_d    = wd_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               owner_d = win;
               len_d   = len_clamped;
               cnt_d   = '0;
               acc_d   = '0;
`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
               err_d   = 1'b0;
               wd_d    = '0;
`endif
               state_d = (len_clamped == '0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (beat) begin
               acc_d = acc_q + prod_ext;
               cnt_d = cnt_q + LW'(1);
`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
               wd_d  = '0;
`endif
               if (cnt_q == len_q - LW'(1)) begin
                  state_d = S_DONE;
               end
            end
`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
            else if (wd_q == WDW'(TIMEOUT - 1)) begin
               // Abort keeps the partial sum so the consumer can see how far the job got.
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
`endif
         end
         S_DONE: begin
            if (res_ready) begin
               ptr_d   = ~owner_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         ptr_q   <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
         err_q   <= 1'b0;
         wd_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
         err_q   <= err_d;
         wd_q    <= wd_d;
`endif
      end
   end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Self-checking bench for mac_job_arbiter: vector table, hand-written corner sequences,
// and randomized jobs checked against a dot-product / round-robin reference model.
module tb_mac_job_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [3:0]  len0 = '0, len1 = '0;
   logic [3:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        valid0 = 1'b0, valid1 = 1'b0;
   logic        ready0, ready1;
   logic [1:0]  gnt;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [10:0] res_data;
   logic        res_id;
   logic        res_err;

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;

   mac_job_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .len0(len0), .len1(len1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .valid0(valid0), .valid1(valid1), .ready0(ready0), .ready1(ready1),
      .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .res_err(res_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          r0, r1;
      int          l0, l1;
      logic [31:0] a0p, b0p, a1p, b1p;
      int          exp_id, exp_beats, exp_res;
   } vec_t;

   vec_t tv[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int s4(input logic [3:0] n);
      return int'($signed(n));
   endfunction

   function automatic int model_dot(input logic [31:0] ap, input logic [31:0] bp, input int len);
      int n = (len > 8) ? 8 : len;
      int s = 0;
      for (int k = 0; k < n; k++) s += s4(ap[4*k +: 4]) * s4(bp[4*k +: 4]);
      return s;
   endfunction

   task automatic do_reset();
      reset = 1'b1; req0 = 0; req1 = 0; valid0 = 0; valid1 = 0; res_ready = 0;
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_ready", 32'({ready1, ready0}), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_data", 32'(res_data), 0);
      chk("rst_res_id_err", 32'({res_id, res_err}), 0);
      reset = 1'b0;
      ptr_m = 0;
   endtask

   task automatic accept();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("accept_res_valid", 32'(res_valid), 0);
   endtask

   // Runs one job from IDLE through result acceptance; expectations come from the caller.
   task automatic run_job(input string name, input bit r0, input bit r1, input int l0, input int l1,
                          input logic [31:0] a0p, input logic [31:0] b0p,
                          input logic [31:0] a1p, input logic [31:0] b1p,
                          input int exp_id, input int exp_beats, input int exp_res,
                          input bit drop, input bit stall_en, input int bp);
      int k = 0, cyc = 0, stall = 0;
      bit v;
      logic [10:0] e11 = exp_res[10:0];
      logic [1:0]  g1h = (exp_id == 1) ? 2'b10 : 2'b01;
      req0 = r0; req1 = r1; len0 = l0[3:0]; len1 = l1[3:0];
      valid0 = 0; valid1 = 0; res_ready = 0;
      tick();
      if (drop) begin req0 = 0; req1 = 0; end
      len0 = 4'($urandom); len1 = 4'($urandom);
      if (exp_beats == 0) chk({name, "_gnt_zero"}, 32'(gnt), 0);
      else                chk({name, "_gnt"}, 32'(gnt), 32'(g1h));
      while (k < exp_beats && cyc < 100) begin
         chk({name, "_ready"}, 32'({ready1, ready0}), 32'(g1h));
         v = !stall_en || (stall >= 3) || ($urandom_range(0, 3) != 0);
         a0 = a0p[4*k +: 4]; b0 = b0p[4*k +: 4];
         a1 = a1p[4*k +: 4]; b1 = b1p[4*k +: 4];
         valid0 = v; valid1 = v;
         tick();
         if (v) begin k++; stall = 0; end else stall++;
         cyc++;
      end
      if (cyc >= 100) chk({name, "_beat_timeout"}, 1, 0);
      // Extra valid beats during DONE must not be accepted.
      valid0 = 1; valid1 = 1; a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      chk({name, "_res_valid"}, 32'(res_valid), 1);
      chk({name, "_res_data"}, 32'(res_data), 32'(e11));
      chk({name, "_res_id"}, 32'(res_id), exp_id);
      chk({name, "_res_err"}, 32'(res_err), 0);
      chk({name, "_done_gnt_ready"}, 32'({gnt, ready1, ready0}), 0);
      for (int i = 0; i < bp; i++) begin
         tick();
         chk({name, "_bp_hold"}, 32'({res_valid, res_id, res_data}), 32'({1'b1, exp_id[0], e11}));
         chk({name, "_bp_gnt"}, 32'(gnt), 0);
      end
      accept();
      valid0 = 0; valid1 = 0;
      ptr_m = 1 - exp_id;
   endtask

   initial begin
      tv[0] = '{"basic",     1, 0, 3, 0,  32'h0000_07F2, 32'h0000_0843, 32'h0, 32'h0, 0, 3, -54};
      tv[1] = '{"clamp_max", 0, 1, 0, 12, 32'h0, 32'h0, 32'h8888_8888, 32'h8888_8888, 1, 8, 512};
      tv[2] = '{"zero_len",  1, 0, 0, 0,  32'h0000_0077, 32'h0000_0077, 32'h0, 32'h0, 0, 0, 0};
      tv[3] = '{"both_ptr1", 1, 1, 5, 2,  32'h0001_1111, 32'h0001_1111, 32'h0000_0033, 32'h0000_00EE, 1, 2, -12};
      tv[4] = '{"mixed",     1, 0, 4, 0,  32'h0000_C058, 32'h0000_CD57, 32'h0, 32'h0, 0, 4, -15};
      tv[5] = '{"single1",   0, 1, 0, 1,  32'h0, 32'h0, 32'h0000_0007, 32'h0000_0007, 1, 1, 49};

      do_reset();
      for (int i = 0; i < 6; i++)
         run_job(tv[i].name, tv[i].r0, tv[i].r1, tv[i].l0, tv[i].l1, tv[i].a0p, tv[i].b0p,
                 tv[i].a1p, tv[i].b1p, tv[i].exp_id, tv[i].exp_beats, tv[i].exp_res, 1, 0, 1);

      // Both requesters held from reset: grants alternate 0,1,0,1.
      do_reset();
      for (int i = 0; i < 4; i++)
         run_job("alternate", 1, 1, 2, 2, 32'h11, 32'h11, 32'h33, 32'hEE,
                 i % 2, 2, (i % 2 == 0) ? 2 : -12, 0, 0, 0);

      // Result backpressure with a pending req1 that must wait for acceptance.
      req0 = 1; len0 = 1; tick(); req0 = 0;
      req1 = 1; len1 = 1; a0 = 2; b0 = 2; valid0 = 1; tick(); valid0 = 0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", 32'({res_valid, res_id, res_data}), 32'({1'b1, 1'b0, 11'd4}));
         chk("bp_no_grant", 32'(gnt), 0);
         tick();
      end
      accept();
      run_job("bp_pending1", 0, 1, 0, 1, 32'h0, 32'h0, 32'h5, 32'h3, 1, 1, 15, 1, 0, 0);

      // Randomized jobs against the reference model.
      for (int r = 0; r < 40; r++) begin
         bit rr0, rr1;
         int l0, l1, w, wl;
         logic [31:0] ap0, bp0, ap1, bp1;
         rr0 = 1'($urandom); rr1 = 1'($urandom);
         if (!rr0 && !rr1) rr0 = 1;
         l0 = $urandom_range(0, 11); l1 = $urandom_range(0, 11);
         ap0 = $urandom; bp0 = $urandom; ap1 = $urandom; bp1 = $urandom;
         w  = (rr0 && rr1) ? ptr_m : (rr1 ? 1 : 0);
         wl = (w == 1) ? l1 : l0;
         run_job("rand", rr0, rr1, l0, l1, ap0, bp0, ap1, bp1, w, (wl > 8) ? 8 : wl,
                 (w == 1) ? model_dot(ap1, bp1, wl) : model_dot(ap0, bp0, wl),
                 1'($urandom), 1, $urandom_range(0, 3));
      end

      // Reset in the middle of a job, with the pointer pointing at requester 1.
      run_job("pre_mid", 1, 0, 1, 0, 32'h1, 32'h1, 32'h0, 32'h0, 0, 1, 1, 1, 0, 0);
      req1 = 1; len1 = 4; tick(); req1 = 0;
      chk("mid_gnt", 32'(gnt), 2);
      a1 = 3; b1 = 3; valid1 = 1; tick(); tick();
      reset = 1; tick();
      valid1 = 0;
      chk("mid_rst_gnt_ready", 32'({gnt, ready1, ready0}), 0);
      chk("mid_rst_res", 32'({res_valid, res_id, res_err, res_data}), 0);
      reset = 0; ptr_m = 0;
      run_job("post_rst", 1, 1, 1, 1, 32'h2, 32'h3, 32'h5, 32'h5, 0, 1, 6, 1, 0, 0);

      // Stalled job: one beat (3,3), then valid held low.
      req0 = 1; len0 = 4; tick(); req0 = 0;
      a0 = 3; b0 = 3; valid0 = 1; tick(); valid0 = 0;
`ifdef MAC_JOB_ARBITER_TIMEOUT_EN
      repeat (15) tick();
      chk("wd_not_yet", 32'(res_valid), 0);
      tick();
      chk("wd_abort", 32'({res_valid, res_err, res_id, gnt}), 32'({1'b1, 1'b1, 1'b0, 2'b00}));
      chk("wd_partial", 32'(res_data), 9);
      accept();
`else
      repeat (20) tick();
      chk("stall_wait", 32'({res_valid, gnt}), 32'({1'b0, 2'b01}));
      a0 = 0; b0 = 0; valid0 = 1;
      repeat (3) tick();
      valid0 = 0;
      chk("stall_done", 32'({res_valid, res_err}), 32'({1'b1, 1'b0}));
      chk("stall_data", 32'(res_data), 9);
      accept();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
